mtimer_slave: RTL and testbench

- Memory-mapped machine timer that responds to the core's data-memory port and drives the core's `interupt` input.
- Sits beside `data_mem` on the writeback-stage load/store bus and uses the same signal set.
- Holds a 64-bit free-running `mtime`, a 64-bit `mtimecmp`, a prescaler and a sticky pending flag.
- Raises a level timer interrupt when `mtime >= mtimecmp`.

---
 rtl/mtimer_slave.sv | 130 +++++++++++++
 tb/tb_mtimer_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mtimer_slave.sv
// rtl/mtimer_slave.sv - memory-mapped 64-bit machine timer with prescaler, compare and sticky pending flag
module mtimer_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
  parameter logic [2:0]  WORD_TYPE = 3'b010
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        red_enable,
  input  logic        write_enable,
  input  logic [2:0]  memory_type,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] redata,
  output logic        hit,
  output logic        time_interupt
);

  localparam logic [7:0] OFF_MTIME_LO = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI = 8'h04;
  localparam logic [7:0] OFF_CMP_LO   = 8'h08;
  localparam logic [7:0] OFF_CMP_HI   = 8'h0C;
  localparam logic [7:0] OFF_CTRL     = 8'h10;
  localparam logic [7:0] OFF_STATUS   = 8'h14;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        cnt_en_q, cnt_en_d;
  logic        int_en_q, int_en_d;
  logic [7:0]  prescale_q, prescale_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        pending_q, pending_d;

  logic valid, wr;
  logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_status;
  logic tick, match;

  assign hit   = (addr[31:8] == BASE_ADDR[31:8]);
  assign valid = hit && (memory_type == WORD_TYPE) && (addr[1:0] == 2'b00);
  assign wr    = write_enable && valid;

  assign wr_mtime_lo = wr && (addr[7:0] == OFF_MTIME_LO);
  assign wr_mtime_hi = wr && (addr[7:0] == OFF_MTIME_HI);
  assign wr_cmp_lo   = wr && (addr[7:0] == OFF_CMP_LO);
  assign wr_cmp_hi   = wr && (addr[7:0] == OFF_CMP_HI);
  assign wr_ctrl     = wr && (addr[7:0] == OFF_CTRL);
  assign wr_status   = wr && (addr[7:0] == OFF_STATUS);

  assign tick  = cnt_en_q && (pcnt_q == prescale_q);
  assign match = (mtime_q >= mtimecmp_q);

  // Both terms are flops, so the AND cannot glitch on bus activity.
  assign time_interupt = pending_q & int_en_q;

  always_comb begin
    pcnt_d = pcnt_q + 8'd1;
    if (!cnt_en_q || wr_ctrl || tick) begin
      pcnt_d = 8'd0;
    end

    // A software write to either half suppresses the increment for that cycle.
    mtime_d = mtime_q;
    if (wr_mtime_lo) begin
      mtime_d[31:0] = writedata;
    end else if (wr_mtime_hi) begin
      mtime_d[63:32] = writedata;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    mtimecmp_d = mtimecmp_q;
    if (wr_cmp_lo) begin
      mtimecmp_d[31:0] = writedata;
    end
    if (wr_cmp_hi) begin
      mtimecmp_d[63:32] = writedata;
    end

    cnt_en_d   = cnt_en_q;
    int_en_d   = int_en_q;
    prescale_d = prescale_q;
    if (wr_ctrl) begin
      cnt_en_d   = writedata[0];
      int_en_d   = writedata[1];
      prescale_d = writedata[15:8];
    end

    pending_d = pending_q;
    if (match) begin
      pending_d = 1'b1;
    end else if (wr_status && writedata[0]) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    redata = 32'h0;
    if (red_enable && valid) begin
      case (addr[7:0])
        OFF_MTIME_LO: redata = mtime_q[31:0];
        OFF_MTIME_HI: redata = mtime_q[63:32];
        OFF_CMP_LO:   redata = mtimecmp_q[31:0];
        OFF_CMP_HI:   redata = mtimecmp_q[63:32];
        OFF_CTRL:     redata = {16'h0, prescale_q, 6'h0, int_en_q, cnt_en_q};
        OFF_STATUS:   redata = {31'h0, pending_q};
        default:      redata = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      cnt_en_q   <= 1'b0;
      int_en_q   <= 1'b0;
      prescale_q <= 8'h0;
      pcnt_q     <= 8'h0;
      pending_q  <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      cnt_en_q   <= cnt_en_d;
      int_en_q   <= int_en_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_mtimer_slave.sv
// tb/tb_mtimer_slave.sv - self-checking bench for mtimer_slave against a behavioural timer model
module tb_mtimer_slave;

  localparam logic [31:0] BASE = 32'h0000_F000;
  localparam logic [2:0]  WORD = 3'b010;

  logic        clock;
  logic        reset;
  logic        red_enable;
  logic        write_enable;
  logic [2:0]  memory_type;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] redata;
  logic        hit;
  logic        time_interupt;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_time, m_cmp;
  logic        m_en, m_ie, m_pend;
  int          m_ps, m_since;

  mtimer_slave #(.BASE_ADDR(BASE), .WORD_TYPE(WORD)) dut (
    .clock(clock), .reset(reset), .red_enable(red_enable), .write_enable(write_enable),
    .memory_type(memory_type), .addr(addr), .writedata(writedata), .redata(redata),
    .hit(hit), .time_interupt(time_interupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_time = 64'h0; m_cmp = '1; m_en = 0; m_ie = 0; m_pend = 0; m_ps = 0; m_since = 0;
  endfunction

  function automatic logic m_valid(input logic [2:0] mt, input logic [31:0] a);
    return (a[31:8] == BASE[31:8]) && (mt == WORD) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] m_read(input logic re, input logic [2:0] mt, input logic [31:0] a);
    if (!(re && m_valid(mt, a))) return 32'h0;
    case (a[7:0])
      8'h00: return m_time[31:0];
      8'h04: return m_time[63:32];
      8'h08: return m_cmp[31:0];
      8'h0C: return m_cmp[63:32];
      8'h10: return {16'h0, m_ps[7:0], 6'h0, m_ie, m_en};
      8'h14: return {31'h0, m_pend};
      default: return 32'h0;
    endcase
  endfunction

  // Counter advances whenever the enabled-cycle count since the last restart completes a period.
  function automatic void m_step(input logic we, input logic [2:0] mt, input logic [31:0] a, input logic [31:0] wd);
    logic        vw, tick, match;
    logic [7:0]  off;
    logic [63:0] nt;
    vw    = we && m_valid(mt, a);
    off   = a[7:0];
    tick  = m_en && ((m_since % (m_ps + 1)) == m_ps);
    match = (m_time >= m_cmp);
    nt = m_time;
    if (vw && off == 8'h00)      nt = {m_time[63:32], wd};
    else if (vw && off == 8'h04) nt = {wd, m_time[31:0]};
    else if (tick)               nt = m_time + 64'd1;
    if (match) m_pend = 1;
    else if (vw && off == 8'h14 && wd[0]) m_pend = 0;
    if (vw && off == 8'h08) m_cmp[31:0] = wd;
    if (vw && off == 8'h0C) m_cmp[63:32] = wd;
    if (vw && off == 8'h10 || !m_en) m_since = 0;
    else m_since = m_since + 1;
    if (vw && off == 8'h10) begin
      m_en = wd[0]; m_ie = wd[1]; m_ps = int'(wd[15:8]);
    end
    m_time = nt;
  endfunction

  task automatic bus(input logic re, input logic we, input logic [2:0] mt, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] got);
    red_enable = re; write_enable = we; memory_type = mt; addr = a; writedata = wd;
    #4;
    got = redata;
    check("redata", redata, m_read(re, mt, a));
    check("irq", time_interupt, m_pend & m_ie);
    check("hit", hit, a[31:8] == BASE[31:8]);
    @(posedge clock);
    m_step(we, mt, a, wd);
    #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] g;
    bus(1'b0, 1'b1, WORD, BASE + 32'(off), d, g);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] g);
    bus(1'b1, 1'b0, WORD, a, 32'h0, g);
  endtask

  task automatic idle(input int n);
    logic [31:0] g;
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, WORD, 32'h0, 32'h0, g);
  endtask

  task automatic wait_irq(input logic lvl, input int max, input string tag, output int n);
    logic found;
    found = 0;
    n = 0;
    for (int i = 0; i < max; i++) begin
      if (time_interupt === lvl) begin found = 1; n = i; break; end
      idle(1);
    end
    check(tag, found, 1'b1);
  endtask

  initial begin
    logic [31:0] g, a, wd;
    logic [7:0]  off;
    int          n, sel;

    reset = 0; red_enable = 0; write_enable = 0; memory_type = WORD; addr = 0; writedata = 0;
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_irq", time_interupt, 1'b0);
    reset = 1;

    rd(BASE + 32'h08, g); check("rst_cmp_lo", g, 32'hFFFF_FFFF);
    rd(BASE + 32'h0C, g); check("rst_cmp_hi", g, 32'hFFFF_FFFF);
    rd(BASE + 32'h10, g); check("rst_ctrl", g, 32'h0);
    rd(BASE + 32'h40, g); check("rst_unmapped", g, 32'h0);

    wr(8'h10, 32'h0000_0301);
    idle(40);
    rd(BASE, g); check("presc_count", g, 32'd10);
    wr(8'h10, 32'h0);
    idle(20);
    rd(BASE, g); check("presc_hold", g, 32'd10);

    wr(8'h00, 32'hFFFF_FFFE);
    wr(8'h04, 32'h0);
    wr(8'h10, 32'h1);
    idle(1);
    wr(8'h10, 32'h0);
    rd(BASE + 32'h04, g); check("carry_hi", g, 32'h1);
    rd(BASE, g);          check("carry_lo", g, 32'h0);

    wr(8'h00, 32'hFFFF_FFFF);
    wr(8'h04, 32'hFFFF_FFFF);
    wr(8'h10, 32'h1);
    wr(8'h10, 32'h0);
    rd(BASE + 32'h04, g); check("wrap_hi", g, 32'h0);
    rd(BASE, g);          check("wrap_lo", g, 32'h0);

    wr(8'h0C, 32'h0);
    wr(8'h08, 32'd100);
    wr(8'h14, 32'h1);
    rd(BASE + 32'h14, g); check("status_clr", g, 32'h0);
    wr(8'h10, 32'h3);
    wait_irq(1'b1, 300, "irq_rise_seen", n);
    check("irq_rise_cycle", n, 101);
    wr(8'h14, 32'h1);
    check("w1c_match_holds", time_interupt, 1'b1);
    wr(8'h08, 32'd1000);
    wr(8'h14, 32'h1);
    check("rearm_clear", time_interupt, 1'b0);
    wait_irq(1'b1, 1200, "irq_rearm_seen", n);
    rd(BASE, g); check("rearm_mtime_ge", g >= 32'd1000, 1'b1);

    wr(8'h10, 32'h1);
    check("mask_off", time_interupt, 1'b0);
    wr(8'h10, 32'h3);
    check("mask_on", time_interupt, 1'b1);
    wr(8'h10, 32'h0);

    bus(1'b0, 1'b1, 3'b000, BASE + 32'h08, 32'h5, g);
    rd(BASE + 32'h08, g); check("byte_store_ignored", g, 32'd1000);
    rd(BASE + 32'h0A, g); check("misaligned_rd", g, 32'h0);
    bus(1'b1, 1'b0, 3'b000, BASE + 32'h08, 32'h0, g); check("byte_rd", g, 32'h0);

    wr(8'h10, 32'h1);
    idle(1);
    wr(8'h00, 32'h55);
    rd(BASE, g); check("collision_lo", g, 32'h55);
    bus(1'b1, 1'b1, WORD, BASE + 32'h08, 32'h1234, g); check("rw_old_value", g, 32'd1000);
    rd(BASE + 32'h08, g); check("rw_new_value", g, 32'h1234);
    wr(8'h10, 32'h3);
    idle(7);

    red_enable = 1; write_enable = 0; memory_type = WORD; addr = BASE;
    reset = 0;
    #1; check("async_rst_mtime", redata, 32'h0);
    check("async_rst_irq", time_interupt, 1'b0);
    addr = BASE + 32'h0C;
    #1; check("async_rst_cmp_hi", redata, 32'hFFFF_FFFF);
    addr = BASE + 32'h10;
    #1; check("async_rst_ctrl", redata, 32'h0);
    m_reset();
    @(posedge clock);
    #1;
    reset = 1;
    wr(8'h10, 32'h0000_0201);
    idle(2);
    rd(BASE, g); check("first_tick_after_rst", g, 32'h0);
    rd(BASE, g); check("first_tick_lands", g, 32'h1);

    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1: off = 8'h00;
        2:    off = 8'h04;
        3:    off = 8'h08;
        4:    off = 8'h0C;
        5, 6: off = 8'h10;
        7, 8: off = 8'h14;
        9:    off = 8'h40;
        default: off = 8'(($urandom_range(0, 7)) << 2);
      endcase
      a = BASE + 32'(off);
      if ($urandom_range(0, 15) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      wd = $urandom;
      if (off == 8'h10) wd[15:10] = 6'h0;
      if (off == 8'h04 || off == 8'h0C) wd = wd & 32'h3;
      if (off == 8'h00 && $urandom_range(0, 3) == 0) wd = 32'hFFFF_FFF0 | wd[3:0];
      bus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : WORD, a, wd, g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
